// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FPU interface definitions: widths, command encodings, flag and response records.
package fpu_issue_ctrl_pkg;

  localparam int unsigned C_OP    = 32;
  localparam int unsigned C_RM    = 2;
  localparam int unsigned C_CMD   = 4;
  localparam int unsigned C_FLAGS = 6;
  localparam int unsigned C_TAG_W = 4;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'd0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'd1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'd2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD = 4'd3;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD = 4'd4;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD = 4'd5;

  typedef struct packed {
    logic of;
    logic uf;
    logic zero;
    logic ix;
    logic iv;
    logic inf;
  } fpu_flags_t;

  typedef struct packed {
    logic [C_OP-1:0]    result;
    fpu_flags_t         flags;
    logic [C_TAG_W-1:0] tag;
  } fpu_resp_t;

endpackage

// File: rtl/fpu_issue_ctrl_resp_fifo.sv
// Synchronous response FIFO: registered storage, no fall-through, occupancy tracked by a
// Depth+1 state counter so full and empty are unambiguous.
module fpu_resp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 42
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Push_SI,
  input  logic [Width-1:0] Data_DI,
  input  logic             Pop_SI,
  output logic [Width-1:0] Data_DO,
  output logic             Full_SO,
  output logic             Empty_SO
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign Full_SO  = (cnt_q == CW'(Depth));
  assign Empty_SO = (cnt_q == '0);
  assign push     = Push_SI & ~Full_SO;
  assign pop      = Pop_SI & ~Empty_SO;
  assign Data_DO  = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wptr_q] = Data_DI;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the counter alone decides what is valid.
  always_ff @(posedge Clk_CI) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the private FPU: tag pipeline mirroring FPU latency, stall back-pressure
// and a response FIFO so no result is ever lost.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned C_FPU_LAT  = 3,
  parameter int unsigned C_FIFO_DEP = 4,
  parameter int unsigned C_TAG      = 4
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic               Req_Valid_SI,
  output logic               Req_Ready_SO,
  input  logic [C_OP-1:0]    Req_Op_a_DI,
  input  logic [C_OP-1:0]    Req_Op_b_DI,
  input  logic [C_RM-1:0]    Req_RM_SI,
  input  logic [C_CMD-1:0]   Req_OP_SI,
  input  logic [C_TAG-1:0]   Req_Tag_DI,
  output logic               Resp_Valid_SO,
  input  logic               Resp_Ready_SI,
  output logic [C_OP-1:0]    Resp_Result_DO,
  output logic [C_FLAGS-1:0] Resp_Flags_DO,
  output logic [C_TAG-1:0]   Resp_Tag_DO,
  output logic [C_OP-1:0]    Fpu_Op_a_DO,
  output logic [C_OP-1:0]    Fpu_Op_b_DO,
  output logic [C_RM-1:0]    Fpu_RM_SO,
  output logic [C_CMD-1:0]   Fpu_OP_SO,
  output logic               Fpu_Enable_SO,
  output logic               Fpu_Stall_SO,
  input  logic [C_OP-1:0]    Fpu_Result_DI,
  input  logic [C_FLAGS-1:0] Fpu_Flags_DI,
  output logic               Busy_SO
);

  typedef struct packed {
    logic [C_OP-1:0]  result;
    fpu_flags_t       flags;
    logic [C_TAG-1:0] tag;
  } resp_t;

  logic [C_FPU_LAT-1:0] vld_q, vld_d;
  logic [C_TAG-1:0]     tag_q [C_FPU_LAT];
  logic [C_TAG-1:0]     tag_d [C_FPU_LAT];
  logic                 en_q, en_d;
  logic                 stall, accept, retire_vld, push;
  logic                 fifo_full, fifo_empty;
  resp_t                push_data, pop_data;

  // FPU captures operands itself; we only forward them.
  assign Fpu_Op_a_DO = Req_Op_a_DI;
  assign Fpu_Op_b_DO = Req_Op_b_DI;
  assign Fpu_RM_SO   = Req_RM_SI;
  assign Fpu_OP_SO   = Req_OP_SI;

  assign retire_vld = vld_q[C_FPU_LAT-1];
  // Registered-only stall: a pop this cycle frees room for next cycle, not this one.
  assign stall      = fifo_full & retire_vld;
  assign accept     = Req_Valid_SI & ~stall;
  assign push       = retire_vld & ~stall;

  assign Fpu_Stall_SO  = stall;
  assign Req_Ready_SO  = ~stall;
  assign Fpu_Enable_SO = en_q;
  assign Busy_SO       = (|vld_q) | ~fifo_empty;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    en_d  = en_q;
    if (!stall) begin
      vld_d[0] = accept;
      tag_d[0] = Req_Tag_DI;
      en_d     = accept;
      for (int unsigned i = 1; i < C_FPU_LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      vld_q <= '0;
      en_q  <= 1'b0;
      for (int unsigned i = 0; i < C_FPU_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      en_q  <= en_d;
      tag_q <= tag_d;
    end
  end

  always_comb begin
    push_data.result = Fpu_Result_DI;
    push_data.flags  = fpu_flags_t'(Fpu_Flags_DI);
    push_data.tag    = tag_q[C_FPU_LAT-1];
  end

  fpu_resp_fifo #(
    .Depth(C_FIFO_DEP),
    .Width($bits(resp_t))
  ) i_resp_fifo (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .Push_SI (push),
    .Data_DI (push_data),
    .Pop_SI  (Resp_Valid_SO & Resp_Ready_SI),
    .Data_DO (pop_data),
    .Full_SO (fifo_full),
    .Empty_SO(fifo_empty)
  );

  assign Resp_Valid_SO  = ~fifo_empty;
  assign Resp_Result_DO = pop_data.result;
  assign Resp_Flags_DO  = pop_data.flags;
  assign Resp_Tag_DO    = pop_data.tag;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a behavioural FPU pipeline model.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  localparam int unsigned LAT = 3;
  localparam int unsigned DEP = 4;
  localparam int unsigned TW  = 4;

  logic               Clk_CI, Rst_RBI;
  logic               Req_Valid_SI, Req_Ready_SO;
  logic [C_OP-1:0]    Req_Op_a_DI, Req_Op_b_DI;
  logic [C_RM-1:0]    Req_RM_SI;
  logic [C_CMD-1:0]   Req_OP_SI;
  logic [TW-1:0]      Req_Tag_DI;
  logic               Resp_Valid_SO, Resp_Ready_SI;
  logic [C_OP-1:0]    Resp_Result_DO;
  logic [C_FLAGS-1:0] Resp_Flags_DO;
  logic [TW-1:0]      Resp_Tag_DO;
  logic [C_OP-1:0]    Fpu_Op_a_DO, Fpu_Op_b_DO;
  logic [C_RM-1:0]    Fpu_RM_SO;
  logic [C_CMD-1:0]   Fpu_OP_SO;
  logic               Fpu_Enable_SO, Fpu_Stall_SO;
  logic [C_OP-1:0]    Fpu_Result_DI;
  logic [C_FLAGS-1:0] Fpu_Flags_DI;
  logic               Busy_SO;

  fpu_issue_ctrl #(
    .C_FPU_LAT (LAT),
    .C_FIFO_DEP(DEP),
    .C_TAG     (TW)
  ) dut (
    .Clk_CI        (Clk_CI),
    .Rst_RBI       (Rst_RBI),
    .Req_Valid_SI  (Req_Valid_SI),
    .Req_Ready_SO  (Req_Ready_SO),
    .Req_Op_a_DI   (Req_Op_a_DI),
    .Req_Op_b_DI   (Req_Op_b_DI),
    .Req_RM_SI     (Req_RM_SI),
    .Req_OP_SI     (Req_OP_SI),
    .Req_Tag_DI    (Req_Tag_DI),
    .Resp_Valid_SO (Resp_Valid_SO),
    .Resp_Ready_SI (Resp_Ready_SI),
    .Resp_Result_DO(Resp_Result_DO),
    .Resp_Flags_DO (Resp_Flags_DO),
    .Resp_Tag_DO   (Resp_Tag_DO),
    .Fpu_Op_a_DO   (Fpu_Op_a_DO),
    .Fpu_Op_b_DO   (Fpu_Op_b_DO),
    .Fpu_RM_SO     (Fpu_RM_SO),
    .Fpu_OP_SO     (Fpu_OP_SO),
    .Fpu_Enable_SO (Fpu_Enable_SO),
    .Fpu_Stall_SO  (Fpu_Stall_SO),
    .Fpu_Result_DI (Fpu_Result_DI),
    .Fpu_Flags_DI  (Fpu_Flags_DI),
    .Busy_SO       (Busy_SO)
  );

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;
  fpu_resp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-known results for the directed vectors; other operands get an easily predicted
  // synthetic function so data integrity through the pipe can still be checked.
  function automatic logic [37:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [C_CMD-1:0] op, input logic [C_RM-1:0] rm);
    if (op == C_FPU_ADD_CMD && a == 32'h3F80_0000 && b == 32'h4000_0000)
      return {32'h4040_0000, 6'b000000};
    if (op == C_FPU_MUL_CMD && a == 32'h7F80_0000 && b == 32'h0000_0000)
      return {32'h7FC0_0000, 6'b000010};
    return {a ^ b, a[5:0] ^ b[5:0] ^ {4'b0, rm}};
  endfunction

  // FPU model: captures operands every non-stalled edge, result after LAT edges.
  logic [37:0] fpu_pipe [LAT];
  always @(posedge Clk_CI) begin
    if (!Fpu_Stall_SO) begin
      for (int i = LAT - 1; i > 0; i--) fpu_pipe[i] <= fpu_pipe[i-1];
      fpu_pipe[0] <= fpu_fn(Fpu_Op_a_DO, Fpu_Op_b_DO, Fpu_OP_SO, Fpu_RM_SO);
    end
  end
  assign Fpu_Result_DI = fpu_pipe[LAT-1][37:6];
  assign Fpu_Flags_DI  = fpu_pipe[LAT-1][5:0];

  // Monitor: pops responses and records accepted requests, sampling at the falling edge.
  always @(negedge Clk_CI) begin
    if (Rst_RBI) begin
      if (Resp_Valid_SO && Resp_Ready_SI) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO}, 64'hDEAD);
        end else begin
          fpu_resp_t e;
          e = exp_q.pop_front();
          check("resp", {Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO}, e);
        end
      end
      if (Req_Valid_SI && Req_Ready_SO) begin
        fpu_resp_t e;
        logic [37:0] r;
        r = fpu_fn(Req_Op_a_DI, Req_Op_b_DI, Req_OP_SI, Req_RM_SI);
        e.result = r[37:6];
        e.flags  = r[5:0];
        e.tag    = Req_Tag_DI;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [C_CMD-1:0] op, input logic [TW-1:0] tag);
    Req_Valid_SI = v;
    Req_Op_a_DI  = a;
    Req_Op_b_DI  = b;
    Req_OP_SI    = op;
    Req_Tag_DI   = tag;
    Req_RM_SI    = 2'd0;
  endtask

  task automatic cycle(output logic acc, output logic rsp);
    @(negedge Clk_CI);
    acc = Req_Valid_SI && Req_Ready_SO;
    rsp = Resp_Valid_SO && Resp_Ready_SI;
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    logic a, r;
    int   c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      cycle(a, r);
      c++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, rsp;
    int   lat, i, first, last, rcnt, resp0;
    logic stall_seen;

    Rst_RBI       = 1'b0;
    Resp_Ready_SI = 1'b0;
    drive(1'b0, '0, '0, C_FPU_ADD_CMD, '0);
    repeat (3) @(posedge Clk_CI);
    #1;
    check("rst_resp_valid", 64'(Resp_Valid_SO), 64'd0);
    check("rst_busy", 64'(Busy_SO), 64'd0);
    check("rst_enable", 64'(Fpu_Enable_SO), 64'd0);
    check("rst_stall", 64'(Fpu_Stall_SO), 64'd0);
    check("rst_req_ready", 64'(Req_Ready_SO), 64'd1);
    Rst_RBI = 1'b1;
    cycle(acc, rsp);

    // 1: single add, latency measured from the request cycle
    Resp_Ready_SI = 1'b1;
    drive(1'b1, 32'h3F80_0000, 32'h4000_0000, C_FPU_ADD_CMD, 4'd5);
    cycle(acc, rsp);
    check("t1_accept", 64'(acc), 64'd1);
    drive(1'b0, '0, '0, C_FPU_ADD_CMD, '0);
    check("t1_enable_hi", 64'(Fpu_Enable_SO), 64'd1);
    cycle(acc, rsp);
    check("t1_enable_lo", 64'(Fpu_Enable_SO), 64'd0);
    lat = 2;
    forever begin
      @(negedge Clk_CI);
      if (Resp_Valid_SO || lat >= 20) break;
      @(posedge Clk_CI);
      #1;
      lat++;
    end
    @(posedge Clk_CI);
    #1;
    check("t1_latency", 64'(lat), 64'(LAT + 1));
    drain("t1_drain", 10);

    // 2: eight back-to-back ops, responses must stream without stall
    i = 0; first = -1; last = -1; rcnt = 0; stall_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (i < 8) drive(1'b1, 32'h0101_0101 * i + 32'h100, 32'h3F80_0000 + i, C_FPU_ADD_CMD, TW'(i));
      else drive(1'b0, '0, '0, C_FPU_ADD_CMD, '0);
      cycle(acc, rsp);
      if (acc) i++;
      if (rsp) begin
        if (first < 0) first = c;
        last = c;
        rcnt++;
      end
      stall_seen |= Fpu_Stall_SO;
    end
    check("t2_accepts", 64'(i), 64'd8);
    check("t2_resp_count", 64'(rcnt), 64'd8);
    check("t2_consecutive", 64'(last - first), 64'd7);
    check("t2_no_stall", 64'(stall_seen), 64'd0);
    check("t2_empty", 64'(exp_q.size()), 64'd0);

    // 3: consumer blocked; only FIFO depth plus pipe depth may be accepted
    Resp_Ready_SI = 1'b0;
    i = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 32'hA000_0000 + i, 32'h5 * i, C_FPU_MUL_CMD, TW'(i + 8));
      cycle(acc, rsp);
      if (acc) i++;
    end
    check("t3_accepts", 64'(i), 64'(DEP + LAT));
    check("t3_req_ready", 64'(Req_Ready_SO), 64'd0);
    check("t3_stall", 64'(Fpu_Stall_SO), 64'd1);
    check("t3_enable_held", 64'(Fpu_Enable_SO), 64'd1);

    // 4: pop while full with a retire pending: stall holds that cycle, push follows
    Resp_Ready_SI = 1'b1;
    cycle(acc, rsp);
    check("t4_pop", 64'(rsp), 64'd1);
    check("t4_stall_held", 64'(acc), 64'd0);
    Resp_Ready_SI = 1'b0;
    cycle(acc, rsp);
    check("t4_stall_released", 64'(acc), 64'd1);
    if (acc) i++;
    drive(1'b1, 32'hA000_0000 + i, 32'h5 * i, C_FPU_MUL_CMD, TW'(i + 8));
    cycle(acc, rsp);
    check("t4_full_again", 64'(acc), 64'd0);
    Resp_Ready_SI = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (i < 10) drive(1'b1, 32'hA000_0000 + i, 32'h5 * i, C_FPU_MUL_CMD, TW'(i + 8));
      else drive(1'b0, '0, '0, C_FPU_ADD_CMD, '0);
      cycle(acc, rsp);
      if (acc) i++;
      if (i == 10 && exp_q.size() == 0) break;
    end
    check("t3_all_accepted", 64'(i), 64'd10);
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    check("t3_idle", 64'(Busy_SO), 64'd0);

    // 5: inf * 0 gives canonical NaN with IV set
    drive(1'b1, 32'h7F80_0000, 32'h0000_0000, C_FPU_MUL_CMD, 4'hA);
    cycle(acc, rsp);
    check("t5_accept", 64'(acc), 64'd1);
    drive(1'b0, '0, '0, C_FPU_ADD_CMD, '0);
    drain("t5_drain", 10);

    // 6: reset with three in flight and two queued
    Resp_Ready_SI = 1'b0;
    i = 0;
    for (int c = 0; c < 10 && i < 5; c++) begin
      drive(1'b1, 32'hC000_0000 + i, 32'h3 * i, C_FPU_SUB_CMD, TW'(i + 1));
      cycle(acc, rsp);
      if (acc) i++;
    end
    check("t6_accepts", 64'(i), 64'd5);
    check("t6_busy_before", 64'(Busy_SO), 64'd1);
    check("t6_valid_before", 64'(Resp_Valid_SO), 64'd1);
    drive(1'b0, '0, '0, C_FPU_ADD_CMD, '0);
    Rst_RBI = 1'b0;
    #1;
    check("t6_rst_valid", 64'(Resp_Valid_SO), 64'd0);
    check("t6_rst_busy", 64'(Busy_SO), 64'd0);
    check("t6_rst_enable", 64'(Fpu_Enable_SO), 64'd0);
    exp_q.delete();
    @(posedge Clk_CI);
    #1;
    Rst_RBI = 1'b1;
    repeat (LAT + 2) cycle(acc, rsp);
    check("t6_post_valid", 64'(Resp_Valid_SO), 64'd0);
    check("t6_post_busy", 64'(Busy_SO), 64'd0);
    Resp_Ready_SI = 1'b1;
    resp0 = n_resp;
    drive(1'b1, 32'h3F80_0000, 32'h4000_0000, C_FPU_ADD_CMD, 4'd3);
    cycle(acc, rsp);
    check("t6_accept", 64'(acc), 64'd1);
    drive(1'b0, '0, '0, C_FPU_ADD_CMD, '0);
    drain("t6_drain", 10);
    check("t6_one_resp", 64'(n_resp - resp0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
